// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 datapath: widths, state encodings, opcodes, ALU ops.
package mu0_pkg;

    localparam int MU0_DATA_W = 16;
    localparam int MU0_ADDR_W = 12;
    localparam int MU0_OP_W   = 4;

    // Fetch/execute encoding of the 1-bit state driven by the MU0 FSM
    localparam logic STATE_FETCH   = 1'b0;
    localparam logic STATE_EXECUTE = 1'b1;

    // Opcodes; 4'h8..4'hF are undefined and execute as NOP
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    typedef enum logic [1:0] {
        ALU_PASS_B = 2'd0,
        ALU_ADD    = 2'd1,
        ALU_SUB    = 2'd2
    } alu_op_e;

endpackage

// File: rtl/mu0_alu.sv
// MU0 ALU: pass-through of the memory operand, or modular add/subtract against ACC.
module mu0_alu
    import mu0_pkg::*;
#(
    parameter int W = MU0_DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] result
);

    // Select the result; carry and borrow are intentionally dropped
    always_comb begin
        result = b;
        case (op)
            ALU_PASS_B: result = b;
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            default:    result = b;
        endcase
    end

endmodule

// File: rtl/mu0_datapath.sv
// MU0 datapath: PC/IR/ACC registers, instruction decode and memory bus driving.
// The FSM supplies fetch/execute; Halted is returned to it and is sticky until reset.
module mu0_datapath
    import mu0_pkg::*;
#(
    parameter int                DATA_W   = MU0_DATA_W,
    parameter int                ADDR_W   = MU0_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              state,
    input  logic [DATA_W-1:0] Din,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Dout,
    output logic              Rd,
    output logic              Wr,
    output logic              Halted,
    output logic [DATA_W-1:0] Acc,
    output logic [ADDR_W-1:0] PC,
    output logic              N,
    output logic              Z
);

    localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] acc_r;
    logic              halted_r;

    logic [MU0_OP_W-1:0] opcode_s;
    logic [ADDR_W-1:0]   operand_s;
    logic                n_s;
    logic                z_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                rd_s;
    logic                wr_s;
    alu_op_e             alu_op_s;
    logic                acc_we_s;
    logic                pc_jmp_s;
    logic                halt_set_s;
    logic [DATA_W-1:0]   alu_res_s;

    assign opcode_s  = ir_r[DATA_W-1 -: MU0_OP_W];
    assign operand_s = ir_r[ADDR_W-1:0];

    // Flags reflect ACC as held at the start of the cycle
    assign n_s = acc_r[DATA_W-1];
    assign z_s = (acc_r == {DATA_W{1'b0}});

    mu0_alu #(.W(DATA_W)) u_alu (
        .a      (acc_r),
        .b      (Din),
        .op     (alu_op_s),
        .result (alu_res_s)
    );

    // Decode: bus strobes, address select and register write enables
    always_comb begin
        addr_s     = pc_r;
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        alu_op_s   = ALU_PASS_B;
        acc_we_s   = 1'b0;
        pc_jmp_s   = 1'b0;
        halt_set_s = 1'b0;
        if (halted_r) begin
            // Frozen: no bus traffic, address follows the normal select
            addr_s = (state == STATE_EXECUTE) ? operand_s : pc_r;
        end else if (state == STATE_FETCH) begin
            rd_s = 1'b1;
        end else begin
            addr_s = operand_s;
            case (opcode_s)
                OP_LDA: begin
                    rd_s     = 1'b1;
                    acc_we_s = 1'b1;
                end
                OP_STA: wr_s = 1'b1;
                OP_ADD: begin
                    rd_s     = 1'b1;
                    acc_we_s = 1'b1;
                    alu_op_s = ALU_ADD;
                end
                OP_SUB: begin
                    rd_s     = 1'b1;
                    acc_we_s = 1'b1;
                    alu_op_s = ALU_SUB;
                end
                OP_JMP:  pc_jmp_s   = 1'b1;
                OP_JGE:  pc_jmp_s   = ~n_s;
                OP_JNE:  pc_jmp_s   = ~z_s;
                OP_STP:  halt_set_s = 1'b1;
                default: alu_op_s   = ALU_PASS_B;
            endcase
        end
    end

    // Architectural registers; everything freezes once halted
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pc_r     <= RESET_PC;
            ir_r     <= {DATA_W{1'b0}};
            acc_r    <= {DATA_W{1'b0}};
            halted_r <= 1'b0;
        end else if (halted_r) begin
            halted_r <= 1'b1;
        end else if (state == STATE_FETCH) begin
            ir_r <= Din;
            pc_r <= pc_r + PC_INC;
        end else begin
            if (acc_we_s) begin
                acc_r <= alu_res_s;
            end
            if (pc_jmp_s) begin
                pc_r <= operand_s;
            end
            if (halt_set_s) begin
                halted_r <= 1'b1;
            end
        end
    end

    assign Addr   = addr_s;
    assign Rd     = rd_s;
    assign Wr     = wr_s;
    assign Dout   = acc_r;
    assign Halted = halted_r;
    assign Acc    = acc_r;
    assign PC     = pc_r;
    assign N      = n_s;
    assign Z      = z_s;

endmodule

// File: tb/tb_mu0_datapath.sv
// Bench for mu0_datapath: toggling fetch/execute FSM, 4K x 16 memory, write scoreboard.
module tb_mu0_datapath;

    localparam int DW = 16;
    localparam int AW = 12;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic          st, st_w;
    logic [DW-1:0] din, dout, acc, din_w, dout_w, acc_w;
    logic [AW-1:0] addr, pc, addr_w, pc_w;
    logic          rd, wr, halted, n_f, z_f;
    logic          rd_w, wr_w, halted_w, n_w, z_w;

    logic [DW-1:0] mem   [0:4095];
    logic [DW-1:0] mem_w [0:4095];
    wr_t           wr_q  [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign din   = mem[addr];
    assign din_w = mem_w[addr_w];

    // Minimal MU0 FSM: alternate fetch/execute until halted
    always @(posedge clk or negedge nreset) begin
        if (!nreset) st <= 1'b0;
        else if (!halted) st <= ~st;
        else st <= st;
    end

    // Same FSM for the wrap-around instance
    always @(posedge clk or negedge nreset) begin
        if (!nreset) st_w <= 1'b0;
        else if (!halted_w) st_w <= ~st_w;
        else st_w <= st_w;
    end

    mu0_datapath dut (
        .Clk(clk), .nReset(nreset), .state(st), .Din(din), .Addr(addr), .Dout(dout),
        .Rd(rd), .Wr(wr), .Halted(halted), .Acc(acc), .PC(pc), .N(n_f), .Z(z_f)
    );

    mu0_datapath #(.RESET_PC(12'hFFF)) dut_w (
        .Clk(clk), .nReset(nreset), .state(st_w), .Din(din_w), .Addr(addr_w), .Dout(dout_w),
        .Rd(rd_w), .Wr(wr_w), .Halted(halted_w), .Acc(acc_w), .PC(pc_w), .N(n_w), .Z(z_w)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: perform memory writes at the edge (pre-update values), compare against scoreboard
    task automatic step();
        wr_t e;
        @(posedge clk);
        if (wr) begin
            mem[addr] = dout;
            if (wr_q.size() == 0) begin
                check_val("wr_unexpected_addr", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                check_val("wr_addr", 32'(addr), 32'(e.a));
                check_val("wr_data", 32'(dout), 32'(e.d));
            end
        end
        if (wr_w) mem_w[addr_w] = dout_w;
        @(negedge clk);
    endtask

    task automatic begin_test();
        nreset = 1'b0;
        #1;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic release_reset();
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic run_until_halt(input int max_cycles);
        int k;
        k = 0;
        while (!halted && k < max_cycles) begin
            step();
            k++;
        end
        check_val("halt_within_budget", 32'(halted), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- Test 1: example program, plus PC wrap on the second instance ----
        for (int i = 0; i < 4096; i++) mem_w[i] = 16'h0000;
        mem_w[12'hFFF] = 16'h0010;
        mem_w[12'h000] = 16'h7000;
        mem_w[12'h010] = 16'h0042;
        begin_test();
        mem[12'h000] = 16'h0010;
        mem[12'h001] = 16'h2011;
        mem[12'h002] = 16'h1012;
        mem[12'h003] = 16'h7000;
        mem[12'h010] = 16'h0005;
        mem[12'h011] = 16'h0003;
        @(negedge clk);
        check_val("rst_pc", 32'(pc), 32'h000);
        check_val("rst_acc", 32'(acc), 32'h0000);
        check_val("rst_halted", 32'(halted), 32'h0);
        check_val("rst_addr", 32'(addr), 32'h000);
        check_val("rst_rd_wr", 32'({rd, wr}), 32'h2);
        check_val("rst_pc_w", 32'(pc_w), 32'hFFF);
        wr_q.push_back('{a: 12'h012, d: 16'h0008});
        release_reset();
        step();
        check_val("e1_pc", 32'(pc), 32'h001);
        check_val("lda_addr", 32'(addr), 32'h010);
        check_val("lda_rd_wr", 32'({rd, wr}), 32'h2);
        check_val("wrap_pc", 32'(pc_w), 32'h000);
        step();
        check_val("lda_acc", 32'(acc), 32'h0005);
        check_val("wrap_lda_acc", 32'(acc_w), 32'h0042);
        check_val("wrap_fetch_addr", 32'(addr_w), 32'h000);
        step();
        step();
        check_val("add_acc", 32'(acc), 32'h0008);
        check_val("add_pc", 32'(pc), 32'h002);
        step();
        check_val("sta_addr", 32'(addr), 32'h012);
        check_val("sta_rd_wr", 32'({rd, wr}), 32'h1);
        check_val("sta_dout", 32'(dout), 32'h0008);
        step();
        check_val("sta_mem", 32'(mem[12'h012]), 32'h0008);
        step();
        check_val("stp_exec_halted", 32'(halted), 32'h0);
        check_val("stp_rd_wr", 32'({rd, wr}), 32'h0);
        step();
        check_val("halt_edge8", 32'(halted), 32'h1);
        check_val("halt_pc", 32'(pc), 32'h004);
        check_val("halt_acc", 32'(acc), 32'h0008);
        check_val("wrap_halted", 32'(halted_w), 32'h1);
        check_val("wrap_halt_pc", 32'(pc_w), 32'h001);
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("halted_bus_idle", 32'({rd, wr}), 32'h0);
        end
        check_val("frozen_pc", 32'(pc), 32'h004);
        check_val("frozen_acc", 32'(acc), 32'h0008);
        check_val("frozen_halted", 32'(halted), 32'h1);
        check_val("t1_wr_pending", 32'(wr_q.size()), 32'h0);
        nreset = 1'b0;
        #1;
        check_val("reset_clears_halt", 32'(halted), 32'h0);

        // ---- Test 2: SUB wrap, flags, conditional jumps ----
        begin_test();
        mem[12'h000] = 16'h3031;
        mem[12'h001] = 16'h5020;
        mem[12'h002] = 16'h6020;
        mem[12'h020] = 16'h7000;
        mem[12'h031] = 16'h0001;
        release_reset();
        step();
        check_val("sub_flags_before", 32'({n_f, z_f}), 32'h1);
        check_val("sub_addr", 32'(addr), 32'h031);
        step();
        check_val("sub_acc", 32'(acc), 32'hFFFF);
        check_val("sub_flags_after", 32'({n_f, z_f}), 32'h2);
        step();
        check_val("jge_rd_wr", 32'({rd, wr}), 32'h0);
        step();
        check_val("jge_not_taken", 32'(pc), 32'h002);
        step();
        step();
        check_val("jne_taken", 32'(pc), 32'h020);
        run_until_halt(10);
        check_val("t2_halt_pc", 32'(pc), 32'h021);

        // ---- Test 3: undefined opcode behaves as NOP ----
        begin_test();
        mem[12'h000] = 16'h0030;
        mem[12'h001] = 16'h4005;
        mem[12'h005] = 16'h8FFF;
        mem[12'h006] = 16'h7000;
        mem[12'h030] = 16'h00AA;
        release_reset();
        repeat (4) step();
        check_val("jmp_pc", 32'(pc), 32'h005);
        step();
        check_val("nop_rd_wr", 32'({rd, wr}), 32'h0);
        step();
        check_val("nop_acc", 32'(acc), 32'h00AA);
        check_val("nop_pc", 32'(pc), 32'h006);
        check_val("nop_next_fetch", 32'(addr), 32'h006);
        run_until_halt(10);

        // ---- Test 4: reset during a store execute cycle ----
        begin_test();
        mem[12'h000] = 16'h0030;
        mem[12'h001] = 16'h1040;
        mem[12'h030] = 16'h00AA;
        mem[12'h040] = 16'h5555;
        release_reset();
        repeat (3) step();
        check_val("pre_rst_wr", 32'(wr), 32'h1);
        nreset = 1'b0;
        #1;
        check_val("mid_rst_pc", 32'(pc), 32'h000);
        check_val("mid_rst_acc", 32'(acc), 32'h0000);
        check_val("mid_rst_halted", 32'(halted), 32'h0);
        check_val("mid_rst_addr", 32'(addr), 32'h000);
        check_val("mid_rst_rd_wr", 32'({rd, wr}), 32'h2);
        step();
        check_val("no_partial_write", 32'(mem[12'h040]), 32'h5555);
        wr_q.push_back('{a: 12'h040, d: 16'h00AA});
        nreset = 1'b1;
        check_val("restart_addr", 32'(addr), 32'h000);
        repeat (4) step();
        check_val("restart_sta_mem", 32'(mem[12'h040]), 32'h00AA);
        check_val("t4_wr_pending", 32'(wr_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
